wb_stage_regfile: RTL and testbench
===================================

Name: wb_stage_regfile

Overview:
- Write-back stage directly downstream of the MEM/WB pipeline register.
- Consumes the registered MEM/WB bundle and performs load-data alignment and sign extension.
- Selects the write-back result and writes the 32x32 integer register file, which serves decode reads with write-through bypass.
- Also keeps a 64-bit retired-instruction counter and a sticky trap record for invalid or misaligned instructions.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- memtoreg_in  in  1  load result select, from MEM/WB.
- regwrite_in  in  1  register write request.
- regin_in  in  2  result select: 00 ALUout, 01 load, 10 immgen, 11 PC_plus4.
- ALUout_in  in  XLEN  ALU result.
- Rdata_in  in  XLEN  raw aligned memory word.
- immgen_in  in  XLEN  immediate, used for LUI.
- PC_plus4_in  in  XLEN  link value.
- inst_data_in  in  XLEN  instruction word; 0 denotes a bubble.
- Data_addr_in  in  XLEN  load byte address.
- invalid_in  in  1  instruction flagged invalid upstream.
- rs1_addr, rs2_addr  in  5 each  decode read addresses.
- rs1_data, rs2_data  out  XLEN each  read data, combinational.
- wb_en  out  1  register-file write this cycle, combinational.
- wb_rd  out  5  write destination, equal to inst[11:7].
- wb_data  out  XLEN  write data, for forwarding.
- instret  out  CNT_W  retired-instruction count.
- trap_valid  out  1  sticky trap flag.
- trap_cause  out  2  01 invalid, 10 misaligned load, 11 illegal load funct3.
- trap_pc  out  XLEN  PC of the trapping instruction (PC_plus4_in - 4).
- trap_clr  in  1  clears the trap record.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers are cleared to 0.
  - instret = 0.
  - trap_valid = 0, trap_cause = 0, trap_pc = 0.
  - Combinational outputs follow from the cleared state.
- Bubble: inst_data_in == 0. A bubble never writes, never retires and never traps.
- Load decode:
  - is_load = memtoreg_in | (regin_in == 01).
  - funct3 = inst[14:12].
  - off = Data_addr_in[1:0].
- Load alignment:
  - LB 000 / LBU 100: take byte off, i.e. Rdata[8*off+7 : 8*off]; sign-extend for LB, zero-extend for LBU.
  - LH 001 / LHU 101: off must be 0 or 2; take Rdata[16*off/2+15 : 16*off/2]; sign- or zero-extend accordingly.
  - LW 010: off must be 0.
  - Misaligned halfword or word load: fault = misaligned.
  - funct3 values 011, 110, 111: fault = illegal.
- Result mux:
  - If is_load, the aligned load value is selected.
  - Otherwise select by regin_in (00 ALUout, 10 immgen, 11 PC_plus4).
  - memtoreg_in has priority over regin_in.
- Write enable: wb_en = regwrite_in & ~bubble & ~invalid_in & ~fault & (wb_rd != 0).
- Register file:
  - Writes on the rising edge when wb_en = 1.
  - Reads of x0 always return 0.
  - Bypass: if wb_en and rsN_addr == wb_rd, rsN_data = wb_data in the same cycle; otherwise the stored value.
- Retire: instret += 1 on the edge when ~bubble & ~invalid_in & ~fault. Wraps modulo 2^CNT_W.
- Trap capture:
  - When ~bubble & (invalid_in | fault) and trap_valid == 0, set trap_valid and capture trap_cause and trap_pc.
  - invalid_in has priority over fault.
  - Later traps while trap_valid = 1 are not recorded (first trap wins); the offending instruction still does not write.
- trap_clr:
  - trap_clr = 1 clears trap_valid on the next edge.
  - If trap_clr and a new trap arrive in the same cycle, the new trap is captured (set wins).
- Latency:
  - Write data is visible through the bypass in the same cycle and from storage from the next cycle.
  - instret and trap outputs are registered, one cycle after the qualifying input.
- Reset asserted mid-stream: any in-flight write is lost and all state clears immediately; operation resumes on the first edge after reset deasserts.

Test Plan:
- Reset, then regin=00, ALUout=0x1234, inst=0x00A00513 (rd=x10), regwrite=1 -> wb_en=1, wb_data=0x1234; reading rs1=x10 the next cycle returns 0x1234; instret=1.
- LB with Rdata=0x80FF7F01 at off=1, then off=3 -> 0x0000007F, then 0xFFFFFF80; LBU at off=3 -> 0x00000080; LH at off=2 -> 0xFFFF80FF.
- LW at addr 0x1002 -> wb_en=0, trap_valid=1, trap_cause=10, trap_pc=PC_plus4-4; instret unchanged; register contents unchanged.
- invalid_in=1 followed by a misaligned LH -> trap_cause stays 01; assert trap_clr with a simultaneous new invalid -> trap_valid stays 1 and trap_pc is updated.
- Write to x0 with data 0xDEAD -> wb_en=0 and rs1_data for x0 = 0. Bypass case: rs2_addr=x5 in the same cycle as a write of 0x55 to x5 -> rs2_data=0x55.
- Preload instret to 2^64-1 via a force, then retire one instruction -> instret=0. Assert reset mid-write -> register is 0 after reset.

Source files
------------

// File: rtl/wb_stage_regfile_if.sv
// MEM/WB pipeline bundle presented to the write-back stage.
// master: the MEM/WB register that drives the bundle; slave: the write-back stage.
interface wb_stage_regfile_if #(
  parameter int XLEN = 32
);
  logic            memtoreg_in;
  logic            regwrite_in;
  logic [1:0]      regin_in;
  logic [XLEN-1:0] ALUout_in;
  logic [XLEN-1:0] Rdata_in;
  logic [XLEN-1:0] immgen_in;
  logic [XLEN-1:0] PC_plus4_in;
  logic [XLEN-1:0] inst_data_in;
  logic [XLEN-1:0] Data_addr_in;
  logic            invalid_in;

  modport master (
    output memtoreg_in, regwrite_in, regin_in, ALUout_in, Rdata_in,
           immgen_in, PC_plus4_in, inst_data_in, Data_addr_in, invalid_in
  );

  modport slave (
    input  memtoreg_in, regwrite_in, regin_in, ALUout_in, Rdata_in,
           immgen_in, PC_plus4_in, inst_data_in, Data_addr_in, invalid_in
  );
endinterface

// File: rtl/wb_stage_regfile.sv
// Write-back stage: load alignment/extension, result select, 32x32 integer
// register file with write-through bypass, retired-instruction counter and
// a sticky first-trap record for invalid or faulting loads.
module wb_stage_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  wb_stage_regfile_if.slave mw,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic [CNT_W-1:0]  instret,
  output logic              trap_valid,
  output logic [1:0]        trap_cause,
  output logic [XLEN-1:0]   trap_pc,
  input  logic              trap_clr
);

  logic            bubble_s;
  logic            is_load_s;
  logic [2:0]      funct3_s;
  logic [1:0]      off_s;
  logic [7:0]      byte_s;
  logic [15:0]     half_s;
  logic [XLEN-1:0] load_val_s;
  logic            misalign_s;
  logic            illegal_s;
  logic            fault_s;
  logic [1:0]      fault_cause_s;
  logic [XLEN-1:0] result_s;
  logic [4:0]      rd_s;
  logic            wen_s;
  logic            retire_s;
  logic            trap_take_s;
  logic [1:0]      trap_cause_s;
  logic            unused_s;

  logic [XLEN-1:0]  regs_r [NREG];
  logic [CNT_W-1:0] instret_r;
  logic             trap_valid_r;
  logic [1:0]       trap_cause_r;
  logic [XLEN-1:0]  trap_pc_r;

  assign bubble_s  = (mw.inst_data_in == {XLEN{1'b0}});
  assign is_load_s = mw.memtoreg_in | (mw.regin_in == 2'b01);
  assign funct3_s  = mw.inst_data_in[14:12];
  assign off_s     = mw.Data_addr_in[1:0];
  assign rd_s      = mw.inst_data_in[11:7];
  assign half_s    = off_s[1] ? mw.Rdata_in[31:16] : mw.Rdata_in[15:0];
  assign unused_s  = ^{mw.inst_data_in[31:15], mw.inst_data_in[6:0], mw.Data_addr_in[XLEN-1:2]};

  // Pick the addressed byte lane of the raw memory word.
  always_comb begin
    byte_s = mw.Rdata_in[7:0];
    case (off_s)
      2'b00:   byte_s = mw.Rdata_in[7:0];
      2'b01:   byte_s = mw.Rdata_in[15:8];
      2'b10:   byte_s = mw.Rdata_in[23:16];
      2'b11:   byte_s = mw.Rdata_in[31:24];
      default: byte_s = mw.Rdata_in[7:0];
    endcase
  end

  // Decode load width, extend the selected lane and detect alignment/encoding faults.
  always_comb begin
    load_val_s = {XLEN{1'b0}};
    misalign_s = 1'b0;
    illegal_s  = 1'b0;
    case (funct3_s)
      3'b000: load_val_s = {{(XLEN-8){byte_s[7]}}, byte_s};
      3'b100: load_val_s = {{(XLEN-8){1'b0}}, byte_s};
      3'b001: begin
        load_val_s = {{(XLEN-16){half_s[15]}}, half_s};
        misalign_s = off_s[0];
      end
      3'b101: begin
        load_val_s = {{(XLEN-16){1'b0}}, half_s};
        misalign_s = off_s[0];
      end
      3'b010: begin
        load_val_s = mw.Rdata_in;
        misalign_s = (off_s != 2'b00);
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Faults only matter for loads; an illegal encoding outranks misalignment.
  always_comb begin
    fault_s       = is_load_s & (misalign_s | illegal_s);
    fault_cause_s = 2'b10;
    if (illegal_s) begin
      fault_cause_s = 2'b11;
    end else begin
      fault_cause_s = 2'b10;
    end
  end

  // Result select: any load form wins over the regin selector.
  always_comb begin
    result_s = mw.ALUout_in;
    if (is_load_s) begin
      result_s = load_val_s;
    end else begin
      case (mw.regin_in)
        2'b00:   result_s = mw.ALUout_in;
        2'b10:   result_s = mw.immgen_in;
        2'b11:   result_s = mw.PC_plus4_in;
        default: result_s = mw.ALUout_in;
      endcase
    end
  end

  assign wen_s    = mw.regwrite_in & ~bubble_s & ~mw.invalid_in & ~fault_s & (rd_s != 5'd0);
  assign retire_s = ~bubble_s & ~mw.invalid_in & ~fault_s;

  // Capture a trap when none is held, or when software is clearing the held one.
  always_comb begin
    trap_take_s  = ~bubble_s & (mw.invalid_in | fault_s) & (~trap_valid_r | trap_clr);
    trap_cause_s = fault_cause_s;
    if (mw.invalid_in) begin
      trap_cause_s = 2'b01;
    end else begin
      trap_cause_s = fault_cause_s;
    end
  end

  // Register file storage; x0 is never written because wen_s excludes rd 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wen_s) begin
      regs_r[rd_s] <= result_s;
    end
  end

  // Read ports with x0 forced to zero and same-cycle write-through bypass.
  always_comb begin
    if (rs1_addr == 5'd0) begin
      rs1_data = {XLEN{1'b0}};
    end else if (wen_s && (rs1_addr == rd_s)) begin
      rs1_data = result_s;
    end else begin
      rs1_data = regs_r[rs1_addr];
    end
    if (rs2_addr == 5'd0) begin
      rs2_data = {XLEN{1'b0}};
    end else if (wen_s && (rs2_addr == rd_s)) begin
      rs2_data = result_s;
    end else begin
      rs2_data = regs_r[rs2_addr];
    end
  end

  // Retired-instruction counter, wrapping naturally at full width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky trap record: first trap wins, clear yields to a simultaneous new trap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_valid_r <= 1'b0;
      trap_cause_r <= 2'b00;
      trap_pc_r    <= {XLEN{1'b0}};
    end else if (trap_take_s) begin
      trap_valid_r <= 1'b1;
      trap_cause_r <= trap_cause_s;
      trap_pc_r    <= mw.PC_plus4_in - {{(XLEN-3){1'b0}}, 3'b100};
    end else if (trap_clr) begin
      trap_valid_r <= 1'b0;
    end
  end

  assign wb_en      = wen_s;
  assign wb_rd      = rd_s;
  assign wb_data    = result_s;
  assign instret    = instret_r;
  assign trap_valid = trap_valid_r;
  assign trap_cause = trap_cause_r;
  assign trap_pc    = trap_pc_r;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed bench for wb_stage_regfile. The driver applies one vector per
// cycle and queues the expected values along with the cycle in which they
// must appear; an independent monitor compares on every falling edge.
module tb_wb_stage_regfile;

  localparam int XLEN  = 32;
  localparam int CNT_W = 64;

  localparam int S_WB_EN = 0, S_WB_DATA = 1, S_RS1 = 2, S_RS2 = 3, S_INSTRET = 4,
                 S_TVALID = 5, S_TCAUSE = 6, S_TPC = 7, S_WB_RD = 8;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [4:0]       rs1_addr, rs2_addr;
  logic [XLEN-1:0]  rs1_data, rs2_data;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic [CNT_W-1:0] instret;
  logic             trap_valid;
  logic [1:0]       trap_cause;
  logic [XLEN-1:0]  trap_pc;
  logic             trap_clr;

  int   cyc_cnt  = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  exp_t sb_q[$];

  wb_stage_regfile_if #(.XLEN(XLEN)) mw ();

  wb_stage_regfile #(.XLEN(XLEN), .NREG(32), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mw         (mw.slave),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .instret    (instret),
    .trap_valid (trap_valid),
    .trap_cause (trap_cause),
    .trap_pc    (trap_pc),
    .trap_clr   (trap_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp used to schedule expectations.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] mk_ld(input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [63:0] pick(input int sel);
    case (sel)
      S_WB_EN:   return {63'd0, wb_en};
      S_WB_DATA: return {32'd0, wb_data};
      S_RS1:     return {32'd0, rs1_data};
      S_RS2:     return {32'd0, rs2_data};
      S_INSTRET: return instret;
      S_TVALID:  return {63'd0, trap_valid};
      S_TCAUSE:  return {62'd0, trap_cause};
      S_TPC:     return {32'd0, trap_pc};
      S_WB_RD:   return {59'd0, wb_rd};
      default:   return 64'd0;
    endcase
  endfunction

  task automatic chk(input int sel, input logic [63:0] v, input int dly, input string nm);
    exp_t e;
    e.cyc  = cyc_cnt + dly;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mw.memtoreg_in  = 1'b0;
    mw.regwrite_in  = 1'b0;
    mw.regin_in     = 2'b00;
    mw.ALUout_in    = 32'd0;
    mw.Rdata_in     = 32'd0;
    mw.immgen_in    = 32'd0;
    mw.PC_plus4_in  = 32'd0;
    mw.inst_data_in = 32'd0;
    mw.Data_addr_in = 32'd0;
    mw.invalid_in   = 1'b0;
    trap_clr        = 1'b0;
    rs1_addr        = 5'd0;
    rs2_addr        = 5'd0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic [31:0] addr,
                         input logic [31:0] pc4);
    idle();
    mw.memtoreg_in  = 1'b1;
    mw.regwrite_in  = 1'b1;
    mw.regin_in     = 2'b01;
    mw.Rdata_in     = rdata;
    mw.Data_addr_in = addr;
    mw.PC_plus4_in  = pc4;
    mw.inst_data_in = mk_ld(f3, rd);
  endtask

  task automatic do_alu(input logic [31:0] inst, input logic [31:0] val,
                        input logic [31:0] pc4);
    idle();
    mw.regwrite_in  = 1'b1;
    mw.regin_in     = 2'b00;
    mw.ALUout_in    = val;
    mw.PC_plus4_in  = pc4;
    mw.inst_data_in = inst;
  endtask

  // Monitor: compare every expectation due this cycle, flag any overdue one.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].cyc == cyc_cnt) begin
          n_cmp = n_cmp + 1;
          if (pick(sb_q[i].sel) !== sb_q[i].val) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     sb_q[i].name, pick(sb_q[i].sel), sb_q[i].val, cyc_cnt);
          end
          sb_q.delete(i);
        end else if (sb_q[i].cyc < cyc_cnt) begin
          n_cmp = n_cmp + 1;
          n_bad = n_bad + 1;
          $display("FAIL %s: never sampled, expected %h", sb_q[i].name, sb_q[i].val);
          sb_q.delete(i);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    idle();
    reset = 1'b0;
    next();
    chk(S_INSTRET, 64'd0, 0, "rst_instret");
    chk(S_TVALID,  64'd0, 0, "rst_trap_valid");
    chk(S_TCAUSE,  64'd0, 0, "rst_trap_cause");
    chk(S_TPC,     64'd0, 0, "rst_trap_pc");
    chk(S_WB_EN,   64'd0, 0, "rst_wb_en");
    next();
    reset = 1'b1;

    // ALU write to x10.
    next();
    do_alu(32'h00A00513, 32'h1234, 32'h104);
    chk(S_WB_EN,   64'd1,      0, "alu_wb_en");
    chk(S_WB_DATA, 64'h1234,   0, "alu_wb_data");
    chk(S_WB_RD,   64'd10,     0, "alu_wb_rd");
    chk(S_INSTRET, 64'd1,      1, "alu_instret");

    next();
    idle();
    rs1_addr = 5'd10;
    chk(S_RS1, 64'h1234, 0, "rd_x10_storage");

    // Load alignment and extension.
    next();
    do_load(3'b000, 5'd11, 32'h80FF7F01, 32'h1001, 32'h200);
    chk(S_WB_EN,   64'd1,           0, "lb_off1_en");
    chk(S_WB_DATA, 64'h0000007F,    0, "lb_off1");
    next();
    do_load(3'b000, 5'd12, 32'h80FF7F01, 32'h1003, 32'h200);
    chk(S_WB_DATA, 64'hFFFFFF80,    0, "lb_off3");
    next();
    do_load(3'b100, 5'd13, 32'h80FF7F01, 32'h1003, 32'h200);
    chk(S_WB_DATA, 64'h00000080,    0, "lbu_off3");
    next();
    do_load(3'b001, 5'd14, 32'h80FF7F01, 32'h1002, 32'h200);
    chk(S_WB_DATA, 64'hFFFF80FF,    0, "lh_off2");
    chk(S_INSTRET, 64'd5,           1, "loads_instret");

    // Misaligned word load traps.
    next();
    do_load(3'b010, 5'd15, 32'hCAFEF00D, 32'h1002, 32'h208);
    chk(S_WB_EN,   64'd0,    0, "lw_mis_en");
    chk(S_TVALID,  64'd1,    1, "lw_mis_tvalid");
    chk(S_TCAUSE,  64'd2,    1, "lw_mis_cause");
    chk(S_TPC,     64'h204,  1, "lw_mis_pc");
    chk(S_INSTRET, 64'd5,    1, "lw_mis_instret");
    next();
    idle();
    rs1_addr = 5'd15;
    chk(S_RS1, 64'd0, 0, "lw_mis_no_write");

    next();
    idle();
    trap_clr = 1'b1;
    chk(S_TVALID, 64'd0, 1, "clr_tvalid");

    // Invalid instruction, then a misaligned LH that must not overwrite it.
    next();
    do_alu(32'h00A00513, 32'h999, 32'h300);
    mw.invalid_in = 1'b1;
    chk(S_WB_EN,   64'd0,   0, "inv_en");
    chk(S_TCAUSE,  64'd1,   1, "inv_cause");
    chk(S_TPC,     64'h2FC, 1, "inv_pc");
    next();
    do_load(3'b001, 5'd16, 32'h12345678, 32'h1001, 32'h400);
    chk(S_WB_EN,   64'd0,   0, "lh_mis_en");
    chk(S_TCAUSE,  64'd1,   1, "first_trap_cause");
    chk(S_TPC,     64'h2FC, 1, "first_trap_pc");
    chk(S_INSTRET, 64'd5,   1, "traps_instret");

    // Clear together with a new trap: the new trap is recorded.
    next();
    do_alu(32'h00A00513, 32'h999, 32'h500);
    mw.invalid_in = 1'b1;
    trap_clr      = 1'b1;
    chk(S_TVALID, 64'd1,   1, "clr_set_tvalid");
    chk(S_TPC,    64'h4FC, 1, "clr_set_pc");

    // Write to x0 is suppressed.
    next();
    do_alu(32'h00000013, 32'hDEAD, 32'h600);
    rs1_addr = 5'd0;
    chk(S_WB_EN, 64'd0, 0, "x0_en");
    chk(S_RS1,   64'd0, 0, "x0_read");

    // Same-cycle bypass to x5.
    next();
    do_alu(32'h00000293, 32'h55, 32'h604);
    rs2_addr = 5'd5;
    chk(S_WB_EN,   64'd1,  0, "byp_en");
    chk(S_RS2,     64'h55, 0, "byp_rs2");
    chk(S_INSTRET, 64'd7,  1, "byp_instret");
    next();
    idle();
    rs2_addr = 5'd5;
    chk(S_RS2, 64'h55, 0, "x5_storage");

    // Counter wrap.
    next();
    idle();
    force dut.instret_r = {64{1'b1}};
    #2;
    release dut.instret_r;
    chk(S_INSTRET, {64{1'b1}}, 0, "instret_preload");
    next();
    do_alu(32'h00000313, 32'h1, 32'h608);
    chk(S_INSTRET, 64'd0, 1, "instret_wrap");

    // Reset during a pending write.
    next();
    do_alu(32'h00000393, 32'h77, 32'h60C);
    #6;
    reset = 1'b0;
    next();
    idle();
    next();
    reset = 1'b1;
    rs1_addr = 5'd7;
    rs2_addr = 5'd5;
    chk(S_RS1,     64'd0, 0, "rst_mid_x7");
    chk(S_RS2,     64'd0, 0, "rst_mid_x5");
    chk(S_INSTRET, 64'd0, 0, "rst_mid_instret");

    repeat (3) next();
    for (int i = 0; i < sb_q.size(); i++) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: left unchecked, expected %h", sb_q[i].name, sb_q[i].val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
